// File: rtl/ps2_scancode_filter.sv
// PS/2 set-2 scan-code parser: pops bytes from a first-word-fall-through FIFO and emits
// one event per key press. Break codes, Pause payload and (optionally) typematic repeats are dropped.
module ps2_scancode_filter #(
   parameter bit REPEAT_FILTER = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       empty,
   input  logic [7:0] code,
   output logic       r_en,
   output logic       key_valid,
   input  logic       key_ready,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       err
);

   typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

   state_t     state_q, state_d;
   logic [2:0] skip_q, skip_d;
   logic       held_vld_q, held_vld_d;
   logic [7:0] held_code_q, held_code_d;
   logic       held_ext_q, held_ext_d;
   logic       key_valid_q, key_valid_d;
   logic [7:0] key_code_q, key_code_d;
   logic       key_ext_q, key_ext_d;
   logic       err_q, err_d;

   logic is_err;
   logic make_ev, brk_ev, pause_ev, ev_ext, held_match;

   // A byte may only be popped when the output register is free or is being drained this edge.
   assign r_en      = !empty && !(key_valid_q && !key_ready);
   assign is_err    = (code == 8'h00) || (code == 8'hFF);
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign key_ext   = key_ext_q;
   assign err       = err_q;

   always_comb begin
      state_d     = state_q;
      skip_d      = skip_q;
      held_vld_d  = held_vld_q;
      held_code_d = held_code_q;
      held_ext_d  = held_ext_q;
      key_valid_d = key_valid_q;
      key_code_d  = key_code_q;
      key_ext_d   = key_ext_q;
      err_d       = 1'b0;
      make_ev     = 1'b0;
      brk_ev      = 1'b0;
      pause_ev    = 1'b0;
      ev_ext      = 1'b0;

      if (key_valid_q && key_ready)
         key_valid_d = 1'b0;

      if (r_en) begin
         case (state_q)
            IDLE: begin
               if (code == 8'hE0) begin
                  state_d = EXT;
               end else if (code == 8'hF0) begin
                  state_d = BRK;
               end else if (code == 8'hE1) begin
                  state_d = PAUSE;
                  skip_d  = 3'd7;
               end else if (is_err) begin
                  err_d = 1'b1;
               end else begin
                  make_ev = 1'b1;
               end
            end
            EXT: begin
               ev_ext = 1'b1;
               if (code == 8'hF0) begin
                  state_d = EXT_BRK;
               end else begin
                  state_d = IDLE;
                  err_d   = is_err;
                  make_ev = !is_err;
               end
            end
            BRK, EXT_BRK: begin
               ev_ext  = (state_q == EXT_BRK);
               state_d = IDLE;
               err_d   = is_err;
               brk_ev  = !is_err;
            end
            PAUSE: begin
               // Pause payload is opaque: only counted, never decoded.
               if (skip_q <= 3'd1) begin
                  skip_d   = 3'd0;
                  pause_ev = 1'b1;
                  state_d  = IDLE;
               end else begin
                  skip_d = skip_q - 3'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      held_match = held_vld_q && (held_code_q == code) && (held_ext_q == ev_ext);

      if (make_ev) begin
         held_vld_d  = 1'b1;
         held_code_d = code;
         held_ext_d  = ev_ext;
         if (!(REPEAT_FILTER && held_match)) begin
            key_valid_d = 1'b1;
            key_code_d  = code;
            key_ext_d   = ev_ext;
         end
      end

      if (brk_ev && held_match)
         held_vld_d = 1'b0;

      if (pause_ev) begin
         key_valid_d = 1'b1;
         key_code_d  = 8'hE1;
         key_ext_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         skip_q      <= 3'd0;
         held_vld_q  <= 1'b0;
         held_code_q <= 8'h00;
         held_ext_q  <= 1'b0;
         key_valid_q <= 1'b0;
         key_code_q  <= 8'h00;
         key_ext_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         skip_q      <= skip_d;
         held_vld_q  <= held_vld_d;
         held_code_q <= held_code_d;
         held_ext_q  <= held_ext_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         key_ext_q   <= key_ext_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_ps2_scancode_filter.sv
// Scoreboard bench for ps2_scancode_filter: stimulus is issued as key actions whose expected
// events come from an action-level keyboard model; a negedge monitor pops and compares.
module tb_ps2_scancode_filter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       empty = 1'b1;
   logic [7:0] code = 8'h00;
   logic       key_ready = 1'b0;
   logic       r_en;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ext;
   logic       err;

   ps2_scancode_filter #(.REPEAT_FILTER(1'b1)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .empty(empty),
      .code(code),
      .r_en(r_en),
      .key_valid(key_valid),
      .key_ready(key_ready),
      .key_code(key_code),
      .key_ext(key_ext),
      .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [7:0] fifo[$];
   logic [8:0] expQ[$];
   int   readyMode = 0;
   bit   popPending = 1'b0;
   int   errSeen = 0;
   int   errExpected = 0;
   bit   prevStall = 1'b0;
   logic [7:0] prevCode;
   logic prevExt;

   bit   heldVld = 1'b0;
   logic [7:0] heldCode = 8'h00;
   bit   heldExt = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // FIFO model: the head byte is removed on the edge where r_en was seen high.
   always @(posedge clk) begin
      #1;
      if (popPending && fifo.size() > 0)
         fifo.delete(0);
      popPending = 1'b0;
      empty = (fifo.size() == 0);
      code  = empty ? 8'h00 : fifo[0];
      case (readyMode)
         1:       key_ready = 1'b1;
         2:       key_ready = 1'b0;
         default: key_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Monitor: compares accepted events against the scoreboard queue.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("r_en_rule", {31'd0, r_en}, {31'd0, !empty && !(key_valid && !key_ready)});
         popPending = r_en;
         if (prevStall) begin
            checkOutput("stall_valid", {31'd0, key_valid}, 32'd1);
            checkOutput("stall_code", {24'd0, key_code}, {24'd0, prevCode});
            checkOutput("stall_ext", {31'd0, key_ext}, {31'd0, prevExt});
         end
         if (key_valid === 1'b1 && key_ready) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_event: got %0h ext %0b, expected none", key_code, key_ext);
            end else begin
               logic [8:0] e;
               e = expQ.pop_front();
               checkOutput("event_code", {24'd0, key_code}, {24'd0, e[7:0]});
               checkOutput("event_ext", {31'd0, key_ext}, {31'd0, e[8]});
            end
         end
         if (err === 1'b1)
            errSeen++;
         prevStall = key_valid && !key_ready;
         prevCode  = key_code;
         prevExt   = key_ext;
      end else begin
         popPending = 1'b0;
         prevStall  = 1'b0;
      end
   end

   task automatic applyStimulus(input logic [7:0] b);
      fifo.push_back(b);
   endtask

   task automatic pressKey(input logic [7:0] c, input bit ext);
      if (ext) applyStimulus(8'hE0);
      applyStimulus(c);
      if (!(heldVld && heldCode == c && heldExt == ext))
         expQ.push_back({ext, c});
      heldVld  = 1'b1;
      heldCode = c;
      heldExt  = ext;
   endtask

   task automatic releaseKey(input logic [7:0] c, input bit ext);
      if (ext) applyStimulus(8'hE0);
      applyStimulus(8'hF0);
      applyStimulus(c);
      if (heldVld && heldCode == c && heldExt == ext)
         heldVld = 1'b0;
   endtask

   task automatic pauseKey(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                           input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] p5,
                           input logic [7:0] p6);
      applyStimulus(8'hE1);
      applyStimulus(p0); applyStimulus(p1); applyStimulus(p2); applyStimulus(p3);
      applyStimulus(p4); applyStimulus(p5); applyStimulus(p6);
      expQ.push_back({1'b0, 8'hE1});
   endtask

   task automatic errorSeq(input int kind, input logic [7:0] eb);
      if (kind == 1 || kind == 3) applyStimulus(8'hE0);
      if (kind == 2 || kind == 3) applyStimulus(8'hF0);
      applyStimulus(eb);
      errExpected++;
   endtask

   task automatic waitIdle();
      int n = 0;
      while ((fifo.size() != 0 || key_valid || expQ.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain_timeout: fifo %0d pending %0d, expected 0", fifo.size(), expQ.size());
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #800000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   logic [7:0] keyTable[6] = '{8'h1C, 8'h32, 8'h14, 8'h75, 8'h6B, 8'h5A};

   initial begin
      repeat (3) @(negedge clk);
      checkOutput("reset_valid", {31'd0, key_valid}, 32'd0);
      checkOutput("reset_code", {24'd0, key_code}, 32'd0);
      checkOutput("reset_ext", {31'd0, key_ext}, 32'd0);
      checkOutput("reset_err", {31'd0, err}, 32'd0);
      checkOutput("reset_r_en", {31'd0, r_en}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      readyMode = 1;

      pressKey(8'h1C, 1'b0); releaseKey(8'h1C, 1'b0);
      waitIdle();
      pressKey(8'h75, 1'b1); releaseKey(8'h75, 1'b1);
      pressKey(8'h1C, 1'b0); pressKey(8'h1C, 1'b0); pressKey(8'h1C, 1'b0);
      releaseKey(8'h1C, 1'b0);
      pressKey(8'h1C, 1'b0); pressKey(8'h1C, 1'b0);
      releaseKey(8'h1C, 1'b0);
      waitIdle();

      @(negedge clk) readyMode = 2;
      pressKey(8'h1C, 1'b0); pressKey(8'h32, 1'b0);
      repeat (10) @(negedge clk);
      checkOutput("stall_r_en_low", {31'd0, r_en}, 32'd0);
      checkOutput("stall_fifo_nonempty", {31'd0, empty}, 32'd0);
      checkOutput("stall_first_code", {24'd0, key_code}, 32'h1C);
      readyMode = 1;
      @(negedge clk);
      checkOutput("release_code_1C", {24'd0, key_code}, 32'h1C);
      @(negedge clk);
      checkOutput("next_code_32", {24'd0, key_code}, 32'h32);
      checkOutput("next_valid", {31'd0, key_valid}, 32'd1);
      waitIdle();
      releaseKey(8'h32, 1'b0);

      pauseKey(8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77);
      waitIdle();
      errorSeq(1, 8'hFF);
      pressKey(8'h1C, 1'b0);
      waitIdle();
      releaseKey(8'h1C, 1'b0);
      waitIdle();

      applyStimulus(8'hF0);
      waitIdle();
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midreset_valid", {31'd0, key_valid}, 32'd0);
      checkOutput("midreset_err", {31'd0, err}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      heldVld = 1'b0;
      pressKey(8'h1C, 1'b0);
      waitIdle();

      readyMode = 0;
      for (int i = 0; i < 300; i++) begin
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 4) begin
            pressKey(keyTable[$urandom_range(0, 5)], bit'($urandom_range(0, 1)));
         end else if (sel < 7) begin
            if (heldVld && $urandom_range(0, 1) == 1)
               releaseKey(heldCode, heldExt);
            else
               releaseKey(keyTable[$urandom_range(0, 5)], bit'($urandom_range(0, 1)));
         end else if (sel < 8) begin
            pauseKey(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)));
         end else begin
            errorSeq($urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00);
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      readyMode = 1;
      waitIdle();
      checkOutput("scoreboard_drained", expQ.size(), 32'd0);
      checkOutput("err_pulse_count", errSeen, errExpected);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
